// File: rtl/pic_pkg.sv
// Shared definitions for the PIC datapath: OCW2 command encodings and the
// INTA sequencing state type.
package pic_pkg;

  // OCW2 {R,SL,EOI} command encodings
  localparam logic [2:0] CMD_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] CMD_NS_EOI       = 3'b001;
  localparam logic [2:0] CMD_NOP          = 3'b010;
  localparam logic [2:0] CMD_SP_EOI       = 3'b011;
  localparam logic [2:0] CMD_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] CMD_ROT_NS       = 3'b101;
  localparam logic [2:0] CMD_SET_PRI      = 3'b110;
  localparam logic [2:0] CMD_ROT_SP       = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    WAIT2 = 1'b1
  } inta_state_e;

endpackage

// File: rtl/rot_prio_enc.sv
// Rotating-priority encoder: the level just above low_ptr has the highest
// priority. Rotates the vector, fixed-priority encodes, then adds the offset back.
module rot_prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] vec,
  input  logic [IDX_W-1:0]   low_ptr,
  output logic               vld,
  output logic [IDX_W-1:0]   id
);

  logic [IDX_W-1:0]     start;
  logic [2*NUM_IRQ-1:0] dbl;
  logic [NUM_IRQ-1:0]   rot;
  logic [IDX_W-1:0]     off;

  // NOTE: every variable written in an always_comb gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    start = low_ptr + IDX_W'(1);
    dbl   = {vec, vec} >> start;
    rot   = dbl[NUM_IRQ-1:0];
    off   = '0;
    // Descending scan so the lowest set position (highest priority) wins.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign vld = |vec;
  assign id  = vld ? (start + off) : low_ptr;

endmodule

// File: rtl/isr_bank.sv
// In-service register bank with rotating priority, EOI decode and INTA sequencing.
// Optional: define ISR_SPECIAL_MASK_EN to add the special-mask-mode ports smm/imr.
module isr_bank
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init,
  input  logic               ack_vld,
  input  logic [IDX_W-1:0]   ack_id,
  input  logic               inta2,
  input  logic               aeoi_mode,
  input  logic               cmd_vld,
  input  logic [2:0]         cmd,
  input  logic [IDX_W-1:0]   cmd_lvl,
`ifdef ISR_SPECIAL_MASK_EN
  input  logic               smm,
  input  logic [NUM_IRQ-1:0] imr,
`endif
  output logic [NUM_IRQ-1:0] isr,
  output logic               hp_vld,
  output logic [IDX_W-1:0]   hp_id,
  output logic [IDX_W-1:0]   low_ptr,
  output logic               err
);

  logic [NUM_IRQ-1:0] isr_q;
  logic [IDX_W-1:0]   low_ptr_q;
  logic               rot_aeoi_q;
  inta_state_e        state_q;
  logic [IDX_W-1:0]   cur_id_q;
  logic               err_q;

  logic [NUM_IRQ-1:0] hp_vec;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [NUM_IRQ-1:0] set_mask;
  logic [NUM_IRQ-1:0] isr_nxt;
  logic [IDX_W-1:0]   low_ptr_nxt;
  logic               rot_aeoi_nxt;
  logic               aeoi_fire;
  logic               err_nxt;

`ifdef ISR_SPECIAL_MASK_EN
  // Masked levels stay in service but are invisible to priority and NS-EOI.
  assign hp_vec = smm ? (isr_q & ~imr) : isr_q;
`else
  assign hp_vec = isr_q;
`endif

  rot_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_hp_enc (
    .vec     (hp_vec),
    .low_ptr (low_ptr_q),
    .vld     (hp_vld),
    .id      (hp_id)
  );

  assign aeoi_fire = (state_q == WAIT2) && inta2 && aeoi_mode;

  // Clears see the pre-update isr/hp_id; the cmd write to low_ptr overrides AEOI rotation.
  always_comb begin
    clr_mask     = '0;
    set_mask     = '0;
    low_ptr_nxt  = low_ptr_q;
    rot_aeoi_nxt = rot_aeoi_q;

    if (aeoi_fire) begin
      clr_mask[cur_id_q] = 1'b1;
      if (rot_aeoi_q) low_ptr_nxt = cur_id_q;
    end

    if (cmd_vld) begin
      unique case (cmd)
        CMD_NS_EOI: begin
          if (hp_vld) clr_mask[hp_id] = 1'b1;
        end
        CMD_SP_EOI: begin
          clr_mask[cmd_lvl] = 1'b1;
        end
        CMD_ROT_NS: begin
          if (hp_vld) begin
            clr_mask[hp_id] = 1'b1;
            low_ptr_nxt     = hp_id;
          end
        end
        CMD_ROT_SP: begin
          clr_mask[cmd_lvl] = 1'b1;
          low_ptr_nxt       = cmd_lvl;
        end
        CMD_SET_PRI:      low_ptr_nxt  = cmd_lvl;
        CMD_ROT_AEOI_SET: rot_aeoi_nxt = 1'b1;
        CMD_ROT_AEOI_CLR: rot_aeoi_nxt = 1'b0;
        CMD_NOP:          ;
        default:          ;
      endcase
    end

    if (ack_vld) set_mask[ack_id] = 1'b1;

    isr_nxt = (isr_q & ~clr_mask) | set_mask;
    err_nxt = (state_q == IDLE) ? inta2 : (ack_vld && !inta2);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isr_q      <= '0;
      low_ptr_q  <= IDX_W'(NUM_IRQ - 1);
      rot_aeoi_q <= 1'b0;
      state_q    <= IDLE;
      cur_id_q   <= '0;
      err_q      <= 1'b0;
    end else if (init) begin
      isr_q      <= '0;
      low_ptr_q  <= IDX_W'(NUM_IRQ - 1);
      rot_aeoi_q <= 1'b0;
      state_q    <= IDLE;
      cur_id_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      isr_q      <= isr_nxt;
      low_ptr_q  <= low_ptr_nxt;
      rot_aeoi_q <= rot_aeoi_nxt;
      err_q      <= err_nxt;
      unique case (state_q)
        IDLE: begin
          if (ack_vld) begin
            state_q  <= WAIT2;
            cur_id_q <= ack_id;
          end
        end
        WAIT2: begin
          // A fresh grant always restarts the wait for the second INTA.
          if (ack_vld) begin
            cur_id_q <= ack_id;
          end else if (inta2) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign isr     = isr_q;
  assign low_ptr = low_ptr_q;
  assign err     = err_q;

endmodule

// File: tb/tb_isr_bank.sv
// Self-checking bench for isr_bank: directed vector table, random run against a
// behavioural model, async-reset, 16-level and special-mask corner cases.
module tb_isr_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init = 1'b0;
  logic       ack_vld = 1'b0;
  logic [2:0] ack_id = '0;
  logic       inta2 = 1'b0;
  logic       aeoi_mode = 1'b0;
  logic       cmd_vld = 1'b0;
  logic [2:0] cmd = '0;
  logic [2:0] cmd_lvl = '0;
  logic [7:0] isr;
  logic       hp_vld;
  logic [2:0] hp_id;
  logic [2:0] low_ptr;
  logic       err;

  logic        ack_vld16 = 1'b0;
  logic [3:0]  ack_id16 = '0;
  logic        inta2_16 = 1'b0;
  logic        cmd_vld16 = 1'b0;
  logic [2:0]  cmd16 = '0;
  logic [3:0]  cmd_lvl16 = '0;
  logic [15:0] isr16;
  logic        hp_vld16;
  logic [3:0]  hp_id16;
  logic [3:0]  low_ptr16;
  logic        err16;

`ifdef ISR_SPECIAL_MASK_EN
  logic        smm = 1'b0;
  logic [7:0]  imr = '0;
  logic        smm16 = 1'b0;
  logic [15:0] imr16 = '0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  isr_bank #(.NUM_IRQ(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .ack_vld   (ack_vld),
    .ack_id    (ack_id),
    .inta2     (inta2),
    .aeoi_mode (aeoi_mode),
    .cmd_vld   (cmd_vld),
    .cmd       (cmd),
    .cmd_lvl   (cmd_lvl),
`ifdef ISR_SPECIAL_MASK_EN
    .smm       (smm),
    .imr       (imr),
`endif
    .isr       (isr),
    .hp_vld    (hp_vld),
    .hp_id     (hp_id),
    .low_ptr   (low_ptr),
    .err       (err)
  );

  isr_bank #(.NUM_IRQ(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .ack_vld   (ack_vld16),
    .ack_id    (ack_id16),
    .inta2     (inta2_16),
    .aeoi_mode (aeoi_mode),
    .cmd_vld   (cmd_vld16),
    .cmd       (cmd16),
    .cmd_lvl   (cmd_lvl16),
`ifdef ISR_SPECIAL_MASK_EN
    .smm       (smm16),
    .imr       (imr16),
`endif
    .isr       (isr16),
    .hp_vld    (hp_vld16),
    .hp_id     (hp_id16),
    .low_ptr   (low_ptr16),
    .err       (err16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model of the 8-level bank: levels as a bit array, priority
  // walked as (low_ptr+k) mod 8 for k = 1..8.
  logic [7:0] m_isr;
  int         m_lp;
  bit         m_ra;
  bit         m_wait;
  int         m_cur;
  bit         m_err;

  task automatic model_reset();
    m_isr  = '0;
    m_lp   = 7;
    m_ra   = 0;
    m_wait = 0;
    m_cur  = 0;
    m_err  = 0;
  endtask

  task automatic model_hp(output bit v, output int id);
    v  = 0;
    id = m_lp;
    for (int k = 1; k <= 8; k++) begin
      if (!v && m_isr[(m_lp + k) % 8]) begin
        v  = 1;
        id = (m_lp + k) % 8;
      end
    end
  endtask

  task automatic model_step();
    bit         hv;
    int         hid;
    int         nlp;
    logic [7:0] nisr;
    if (init) begin
      model_reset();
      return;
    end
    model_hp(hv, hid);
    nisr = m_isr;
    nlp  = m_lp;
    if (m_wait && inta2 && aeoi_mode) begin
      nisr[m_cur] = 1'b0;
      if (m_ra) nlp = m_cur;
    end
    if (cmd_vld) begin
      case (cmd)
        3'b001: if (hv) nisr[hid] = 1'b0;
        3'b011: nisr[cmd_lvl] = 1'b0;
        3'b101: if (hv) begin nisr[hid] = 1'b0; nlp = hid; end
        3'b111: begin nisr[cmd_lvl] = 1'b0; nlp = int'(cmd_lvl); end
        3'b110: nlp = int'(cmd_lvl);
        3'b100: m_ra = 1;
        3'b000: m_ra = 0;
        default: ;
      endcase
    end
    if (ack_vld) nisr[ack_id] = 1'b1;
    m_err = m_wait ? (ack_vld && !inta2) : inta2;
    if (ack_vld) begin
      m_wait = 1;
      m_cur  = int'(ack_id);
    end else if (inta2) begin
      m_wait = 0;
    end
    m_isr = nisr;
    m_lp  = nlp;
  endtask

  task automatic compare_model(input string tag);
    bit v;
    int id;
    model_hp(v, id);
    check({tag, " isr"},     32'(isr),     32'(m_isr));
    check({tag, " hp_vld"},  32'(hp_vld),  32'(v));
    check({tag, " hp_id"},   32'(hp_id),   32'(id));
    check({tag, " low_ptr"}, 32'(low_ptr), 32'(m_lp));
    check({tag, " err"},     32'(err),     32'(m_err));
  endtask

  // Drive one cycle of 8-level inputs, advance the model at the edge, then
  // release the strobes shortly after the edge.
  task automatic apply(input logic av, input logic [2:0] aid, input logic i2, input logic ae,
                       input logic cv, input logic [2:0] c, input logic [2:0] lvl);
    ack_vld   = av;
    ack_id    = aid;
    inta2     = i2;
    aeoi_mode = ae;
    cmd_vld   = cv;
    cmd       = c;
    cmd_lvl   = lvl;
    @(posedge clk);
    model_step();
    #1;
    ack_vld = 1'b0;
    inta2   = 1'b0;
    cmd_vld = 1'b0;
    init    = 1'b0;
  endtask

  task automatic apply16(input logic av, input logic [3:0] aid, input logic i2,
                         input logic cv, input logic [2:0] c, input logic [3:0] lvl);
    ack_vld16 = av;
    ack_id16  = aid;
    inta2_16  = i2;
    cmd_vld16 = cv;
    cmd16     = c;
    cmd_lvl16 = lvl;
    @(posedge clk);
    #1;
    ack_vld16 = 1'b0;
    inta2_16  = 1'b0;
    cmd_vld16 = 1'b0;
  endtask

  typedef struct {
    logic       av;
    logic [2:0] aid;
    logic       i2;
    logic       ae;
    logic       cv;
    logic [2:0] c;
    logic [2:0] lvl;
    logic [7:0] e_isr;
    logic       e_hv;
    logic [2:0] e_hid;
    logic [2:0] e_lp;
    logic       e_err;
  } vec_t;

  vec_t vt[30];

  initial begin
    vt[0]  = '{1, 3, 0, 0, 0, 0, 0, 8'h08, 1, 3, 7, 0};
    vt[1]  = '{0, 0, 1, 0, 0, 0, 0, 8'h08, 1, 3, 7, 0};
    vt[2]  = '{0, 0, 0, 0, 1, 1, 0, 8'h00, 0, 7, 7, 0};
    vt[3]  = '{1, 2, 0, 0, 0, 0, 0, 8'h04, 1, 2, 7, 0};
    vt[4]  = '{0, 0, 1, 0, 0, 0, 0, 8'h04, 1, 2, 7, 0};
    vt[5]  = '{1, 5, 0, 0, 0, 0, 0, 8'h24, 1, 2, 7, 0};
    vt[6]  = '{0, 0, 1, 0, 0, 0, 0, 8'h24, 1, 2, 7, 0};
    vt[7]  = '{0, 0, 0, 0, 1, 6, 3, 8'h24, 1, 5, 3, 0};
    vt[8]  = '{0, 0, 0, 0, 1, 5, 0, 8'h04, 1, 2, 5, 0};
    vt[9]  = '{0, 0, 0, 0, 1, 3, 2, 8'h00, 0, 5, 5, 0};
    vt[10] = '{0, 0, 0, 0, 1, 4, 0, 8'h00, 0, 5, 5, 0};
    vt[11] = '{1, 6, 0, 1, 0, 0, 0, 8'h40, 1, 6, 5, 0};
    vt[12] = '{0, 0, 1, 1, 0, 0, 0, 8'h00, 0, 6, 6, 0};
    vt[13] = '{0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 6, 6, 0};
    vt[14] = '{1, 1, 0, 1, 0, 0, 0, 8'h02, 1, 1, 6, 0};
    vt[15] = '{0, 0, 1, 1, 0, 0, 0, 8'h00, 0, 6, 6, 0};
    vt[16] = '{1, 4, 0, 0, 0, 0, 0, 8'h10, 1, 4, 6, 0};
    vt[17] = '{0, 0, 1, 0, 0, 0, 0, 8'h10, 1, 4, 6, 0};
    vt[18] = '{1, 4, 0, 0, 1, 3, 4, 8'h10, 1, 4, 6, 0};
    vt[19] = '{1, 0, 0, 0, 0, 0, 0, 8'h11, 1, 0, 6, 1};
    vt[20] = '{0, 0, 1, 0, 0, 0, 0, 8'h11, 1, 0, 6, 0};
    vt[21] = '{0, 0, 1, 0, 0, 0, 0, 8'h11, 1, 0, 6, 1};
    vt[22] = '{0, 0, 0, 0, 1, 1, 0, 8'h10, 1, 4, 6, 0};
    vt[23] = '{0, 0, 0, 0, 1, 7, 4, 8'h00, 0, 4, 4, 0};
    vt[24] = '{0, 0, 0, 0, 1, 3, 2, 8'h00, 0, 4, 4, 0};
    vt[25] = '{0, 0, 0, 0, 1, 2, 0, 8'h00, 0, 4, 4, 0};
    vt[26] = '{0, 0, 0, 0, 1, 4, 0, 8'h00, 0, 4, 4, 0};
    vt[27] = '{1, 3, 0, 1, 0, 0, 0, 8'h08, 1, 3, 4, 0};
    vt[28] = '{0, 0, 1, 1, 1, 6, 1, 8'h00, 0, 1, 1, 0};
    vt[29] = '{0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 1, 1, 0};

    model_reset();
    #12;
    check("reset isr",     32'(isr),     32'h00);
    check("reset hp_vld",  32'(hp_vld),  32'h0);
    check("reset hp_id",   32'(hp_id),   32'h7);
    check("reset low_ptr", 32'(low_ptr), 32'h7);
    check("reset err",     32'(err),     32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      apply(vt[i].av, vt[i].aid, vt[i].i2, vt[i].ae, vt[i].cv, vt[i].c, vt[i].lvl);
      check($sformatf("vec%0d isr", i),     32'(isr),     32'(vt[i].e_isr));
      check($sformatf("vec%0d hp_vld", i),  32'(hp_vld),  32'(vt[i].e_hv));
      check($sformatf("vec%0d hp_id", i),   32'(hp_id),   32'(vt[i].e_hid));
      check($sformatf("vec%0d low_ptr", i), 32'(low_ptr), 32'(vt[i].e_lp));
      check($sformatf("vec%0d err", i),     32'(err),     32'(vt[i].e_err));
    end

    // Synchronous init clears service and priority even mid-handshake.
    apply(1, 2, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 6, 2);
    init = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0);
    check("init isr",     32'(isr),     32'h00);
    check("init low_ptr", 32'(low_ptr), 32'h7);
    apply(0, 0, 1, 0, 0, 0, 0);
    check("init idle err", 32'(err), 32'h1);

    // Random run against the model.
    for (int n = 0; n < 1500; n++) begin
      init = ($urandom_range(0, 63) == 0);
      apply(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)));
      compare_model($sformatf("rnd%0d", n));
    end

    // Asynchronous reset in the middle of a WAIT2 with isr = A5.
    init = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0, 0);
    apply(1, 2, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0, 0);
    apply(1, 5, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0, 0);
    apply(1, 7, 0, 0, 0, 0, 0);
    check("pre-rst isr", 32'(isr), 32'hA5);
    #2 rst_n = 1'b0;
    #1;
    check("async rst isr",     32'(isr),     32'h00);
    check("async rst low_ptr", 32'(low_ptr), 32'h7);
    check("async rst hp_vld",  32'(hp_vld),  32'h0);
    #2 rst_n = 1'b1;
    model_reset();
    apply(0, 0, 1, 0, 0, 0, 0);
    check("post-rst idle err", 32'(err), 32'h1);
    check("post-rst isr",      32'(isr), 32'h00);

    // 16-level instance: after rotating to 15, level 0 leads the order.
    init = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0);
    apply16(1, 15, 0, 0, 0, 0);
    check("n16 ack15 hp_id", 32'(hp_id16), 32'hF);
    apply16(0, 0, 1, 0, 0, 0);
    apply16(1, 0, 0, 0, 0, 0);
    apply16(0, 0, 1, 0, 0, 0);
    check("n16 two hp_id", 32'(hp_id16), 32'h0);
    apply16(0, 0, 0, 1, 3'b111, 15);
    check("n16 rotsp isr",     32'(isr16),     32'h0001);
    check("n16 rotsp low_ptr", 32'(low_ptr16), 32'hF);
    check("n16 rotsp hp_vld",  32'(hp_vld16),  32'h1);
    check("n16 rotsp hp_id",   32'(hp_id16),   32'h0);

`ifdef ISR_SPECIAL_MASK_EN
    // Special mask: masked level 1 is skipped by priority and NS-EOI.
    init = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0, 0);
    apply(1, 2, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0, 0);
    check("smm off hp_id", 32'(hp_id), 32'h1);
    smm = 1'b1;
    imr = 8'h02;
    #1;
    check("smm on hp_id", 32'(hp_id), 32'h2);
    apply(0, 0, 0, 0, 1, 3'b001, 0);
    check("smm nseoi isr",    32'(isr),    32'h02);
    check("smm nseoi hp_vld", 32'(hp_vld), 32'h0);
    smm = 1'b0;
    #1;
    check("smm released hp_id", 32'(hp_id), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
